kernel_wg_dispatcher: RTL and testbench

- Synthesizable front-end on the GPU host request port; replaces the testbench-only host driver for multi-workgroup kernels.
- Accepts one kernel descriptor over a valid/ready handshake and expands it into num_wg per-workgroup host requests, wg_id 0..num_wg-1, each with its own PDS base address.
- Throttles outstanding workgroups, consumes completion responses, and pulses kernel_done once every workgroup has reported back.

---
 rtl/kernel_wg_dispatcher.sv | 161 ++++++++++++++++
 tb/tb_kernel_wg_dispatcher.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/kernel_wg_dispatcher.sv
// rtl/kernel_wg_dispatcher.sv - expands one kernel descriptor into per-workgroup host requests,
// throttles outstanding workgroups and pulses kernel_done once every workgroup has completed.
module kernel_wg_dispatcher #(
  parameter int WG_ID_WIDTH     = 15,
  parameter int WF_COUNT_WIDTH  = 4,
  parameter int WAVE_ITEM_WIDTH = 6,
  parameter int MEM_ADDR_WIDTH  = 32,
  parameter int VGPR_ID_WIDTH   = 10,
  parameter int SGPR_ID_WIDTH   = 10,
  parameter int LDS_ID_WIDTH    = 10,
  parameter int MAX_INFLIGHT    = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            knl_valid,
  output logic                            knl_ready,
  input  logic [WG_ID_WIDTH:0]            knl_num_wg,
  input  logic [WF_COUNT_WIDTH-1:0]       knl_num_wf,
  input  logic [WAVE_ITEM_WIDTH-1:0]      knl_wf_size,
  input  logic [MEM_ADDR_WIDTH-1:0]       knl_start_pc,
  input  logic [MEM_ADDR_WIDTH-1:0]       knl_pds_base,
  input  logic [MEM_ADDR_WIDTH-1:0]       knl_pds_stride,
  input  logic [MEM_ADDR_WIDTH-1:0]       knl_csr_knl,
  input  logic [VGPR_ID_WIDTH:0]          knl_vgpr_per_wf,
  input  logic [SGPR_ID_WIDTH:0]          knl_sgpr_per_wf,
  input  logic [LDS_ID_WIDTH:0]           knl_lds_size,
  output logic                            host_req_valid_i,
  input  logic                            host_req_ready_o,
  output logic [WG_ID_WIDTH-1:0]          host_req_wg_id_i,
  output logic [WF_COUNT_WIDTH-1:0]       host_req_num_wf_i,
  output logic [WAVE_ITEM_WIDTH-1:0]      host_req_wf_size_i,
  output logic [MEM_ADDR_WIDTH-1:0]       host_req_start_pc_i,
  output logic [MEM_ADDR_WIDTH-1:0]       host_req_pds_baseaddr_i,
  output logic [MEM_ADDR_WIDTH-1:0]       host_req_csr_knl_i,
  output logic [VGPR_ID_WIDTH:0]          host_req_vgpr_size_total_i,
  output logic [SGPR_ID_WIDTH:0]          host_req_sgpr_size_total_i,
  output logic [LDS_ID_WIDTH:0]           host_req_lds_size_total_i,
  output logic [VGPR_ID_WIDTH:0]          host_req_vgpr_size_per_wf_i,
  output logic [SGPR_ID_WIDTH:0]          host_req_sgpr_size_per_wf_i,
  output logic [3*(WG_ID_WIDTH+1)-1:0]    host_req_kernel_size_3d_i,
  output logic [MEM_ADDR_WIDTH-1:0]       host_req_gds_size_total_i,
  output logic [MEM_ADDR_WIDTH-1:0]       host_req_gds_baseaddr_i,
  input  logic                            host_rsp_valid_o,
  output logic                            host_rsp_ready_i,
  input  logic [WG_ID_WIDTH-1:0]          host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o,
  output logic                            busy,
  output logic                            kernel_done
);

  localparam int NW = WG_ID_WIDTH + 1;
  localparam int VW = VGPR_ID_WIDTH + 1;
  localparam int SW = SGPR_ID_WIDTH + 1;
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [IW-1:0] MAX_IF = IW'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [NW-1:0]              num_wg, issue_cnt, done_cnt;
  logic [IW-1:0]              inflight;
  logic [MEM_ADDR_WIDTH-1:0]  pds_addr, pds_stride;
  logic [VW-1:0]              vgpr_total;
  logic [SW-1:0]              sgpr_total;
  logic                       req_hs, rsp_hs, can_issue;

  assign req_hs    = host_req_valid_i & host_req_ready_o;
  // A response with nothing outstanding is a protocol error and is dropped entirely.
  assign rsp_hs    = host_rsp_valid_o & host_rsp_ready_i & (inflight != '0);
  assign can_issue = (state == ISSUE) && (issue_cnt < num_wg) && (inflight < MAX_IF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    knl_ready        = 1'b0;
    busy             = 1'b1;
    kernel_done      = 1'b0;
    host_rsp_ready_i = 1'b0;
    case (state)
      IDLE: begin
        knl_ready = 1'b1;
        busy      = 1'b0;
        if (knl_valid) state_nxt = (knl_num_wg == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        host_rsp_ready_i = 1'b1;
        if (issue_cnt == num_wg) state_nxt = DRAIN;
      end
      DRAIN: begin
        host_rsp_ready_i = 1'b1;
        if (done_cnt == num_wg) state_nxt = DONE;
      end
      DONE: begin
        kernel_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_wg                      <= '0;
      issue_cnt                   <= '0;
      done_cnt                    <= '0;
      inflight                    <= '0;
      pds_addr                    <= '0;
      pds_stride                  <= '0;
      vgpr_total                  <= '0;
      sgpr_total                  <= '0;
      host_req_valid_i            <= 1'b0;
      host_req_num_wf_i           <= '0;
      host_req_wf_size_i          <= '0;
      host_req_start_pc_i         <= '0;
      host_req_csr_knl_i          <= '0;
      host_req_lds_size_total_i   <= '0;
      host_req_vgpr_size_per_wf_i <= '0;
      host_req_sgpr_size_per_wf_i <= '0;
    end else if (state == IDLE && knl_valid) begin
      num_wg                      <= knl_num_wg;
      issue_cnt                   <= '0;
      done_cnt                    <= '0;
      inflight                    <= '0;
      pds_addr                    <= knl_pds_base;
      pds_stride                  <= knl_pds_stride;
      vgpr_total                  <= {{(VW-WF_COUNT_WIDTH){1'b0}}, knl_num_wf} * knl_vgpr_per_wf;
      sgpr_total                  <= {{(SW-WF_COUNT_WIDTH){1'b0}}, knl_num_wf} * knl_sgpr_per_wf;
      host_req_valid_i            <= 1'b0;
      host_req_num_wf_i           <= knl_num_wf;
      host_req_wf_size_i          <= knl_wf_size;
      host_req_start_pc_i         <= knl_start_pc;
      host_req_csr_knl_i          <= knl_csr_knl;
      host_req_lds_size_total_i   <= knl_lds_size;
      host_req_vgpr_size_per_wf_i <= knl_vgpr_per_wf;
      host_req_sgpr_size_per_wf_i <= knl_sgpr_per_wf;
    end else begin
      if (req_hs) begin
        issue_cnt <= issue_cnt + NW'(1);
        pds_addr  <= pds_addr + pds_stride;
      end
      if (rsp_hs) done_cnt <= done_cnt + NW'(1);
      if (req_hs && !rsp_hs)      inflight <= inflight + IW'(1);
      else if (!req_hs && rsp_hs) inflight <= inflight - IW'(1);
      // Valid drops for one cycle after every handshake so counters settle before the next issue.
      if (req_hs)                             host_req_valid_i <= 1'b0;
      else if (!host_req_valid_i && can_issue) host_req_valid_i <= 1'b1;
    end
  end

  assign host_req_wg_id_i           = issue_cnt[WG_ID_WIDTH-1:0];
  assign host_req_pds_baseaddr_i    = pds_addr;
  assign host_req_vgpr_size_total_i = vgpr_total;
  assign host_req_sgpr_size_total_i = sgpr_total;
  assign host_req_kernel_size_3d_i  = '0;
  assign host_req_gds_size_total_i  = '0;
  assign host_req_gds_baseaddr_i    = '0;

endmodule

// File: tb/tb_kernel_wg_dispatcher.sv
// tb/tb_kernel_wg_dispatcher.sv - randomized bench for kernel_wg_dispatcher against a
// counting reference model of issued/completed workgroups.
module tb_kernel_wg_dispatcher;

  localparam int WG = 15, WF = 4, WI = 6, MA = 32, VG = 10, SG = 10, LD = 10, MAXI = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, knl_valid, knl_ready;
  logic [WG:0]       knl_num_wg;
  logic [WF-1:0]     knl_num_wf;
  logic [WI-1:0]     knl_wf_size;
  logic [MA-1:0]     knl_start_pc, knl_pds_base, knl_pds_stride, knl_csr_knl;
  logic [VG:0]       knl_vgpr_per_wf;
  logic [SG:0]       knl_sgpr_per_wf;
  logic [LD:0]       knl_lds_size;
  logic              req_valid, req_ready;
  logic [WG-1:0]     req_wg_id;
  logic [WF-1:0]     req_num_wf;
  logic [WI-1:0]     req_wf_size;
  logic [MA-1:0]     req_start_pc, req_pds, req_csr;
  logic [VG:0]       req_vgpr_total, req_vgpr_per_wf;
  logic [SG:0]       req_sgpr_total, req_sgpr_per_wf;
  logic [LD:0]       req_lds_total;
  logic [3*(WG+1)-1:0] req_ksize;
  logic [MA-1:0]     req_gds_size, req_gds_base;
  logic              rsp_valid, rsp_ready;
  logic [WG-1:0]     rsp_wg_id;
  logic              busy, kernel_done;

  kernel_wg_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .knl_valid(knl_valid), .knl_ready(knl_ready),
    .knl_num_wg(knl_num_wg), .knl_num_wf(knl_num_wf), .knl_wf_size(knl_wf_size),
    .knl_start_pc(knl_start_pc), .knl_pds_base(knl_pds_base), .knl_pds_stride(knl_pds_stride),
    .knl_csr_knl(knl_csr_knl), .knl_vgpr_per_wf(knl_vgpr_per_wf),
    .knl_sgpr_per_wf(knl_sgpr_per_wf), .knl_lds_size(knl_lds_size),
    .host_req_valid_i(req_valid), .host_req_ready_o(req_ready),
    .host_req_wg_id_i(req_wg_id), .host_req_num_wf_i(req_num_wf),
    .host_req_wf_size_i(req_wf_size), .host_req_start_pc_i(req_start_pc),
    .host_req_pds_baseaddr_i(req_pds), .host_req_csr_knl_i(req_csr),
    .host_req_vgpr_size_total_i(req_vgpr_total), .host_req_sgpr_size_total_i(req_sgpr_total),
    .host_req_lds_size_total_i(req_lds_total), .host_req_vgpr_size_per_wf_i(req_vgpr_per_wf),
    .host_req_sgpr_size_per_wf_i(req_sgpr_per_wf), .host_req_kernel_size_3d_i(req_ksize),
    .host_req_gds_size_total_i(req_gds_size), .host_req_gds_baseaddr_i(req_gds_base),
    .host_rsp_valid_o(rsp_valid), .host_rsp_ready_i(rsp_ready),
    .host_rsp_inflight_wg_buffer_host_wf_done_wg_id_o(rsp_wg_id),
    .busy(busy), .kernel_done(kernel_done)
  );

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic rand_desc(input int n);
    knl_num_wg      = (WG+1)'(n);
    knl_num_wf      = WF'($urandom);
    knl_wf_size     = WI'($urandom);
    knl_start_pc    = $urandom;
    knl_pds_base    = $urandom;
    knl_pds_stride  = $urandom;
    knl_csr_knl     = $urandom;
    knl_vgpr_per_wf = (VG+1)'($urandom);
    knl_sgpr_per_wf = (SG+1)'($urandom);
    knl_lds_size    = (LD+1)'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_idle"}, {knl_ready, busy, kernel_done, req_valid, rsp_ready}, 64'b10000);
  endtask

  // Drives one kernel cycle by cycle; inputs change on negedges, outputs are sampled there too.
  task automatic run_kernel(input int n, input int rdy_pct, input int lat_min, input int lat_max,
                            input bit bogus, input int abort_at, output int max_out);
    int issued, responded, prev_iss, prev_out, j;
    int due[$], ids[$];
    bit last_v, last_hs, seen_done, aborted, exp_v, rdy;
    logic [WF-1:0] d_num_wf; logic [WI-1:0] d_wf_size;
    logic [MA-1:0] d_pc, d_base, d_stride, d_csr, e_pds;
    logic [VG:0] d_vgpr; logic [SG:0] d_sgpr; logic [LD:0] d_lds;
    issued = 0; responded = 0; prev_iss = 0; prev_out = 0; max_out = 0;
    last_v = 0; last_hs = 0; seen_done = 0; aborted = 0;
    d_num_wf = knl_num_wf; d_wf_size = knl_wf_size; d_pc = knl_start_pc; d_base = knl_pds_base;
    d_stride = knl_pds_stride; d_csr = knl_csr_knl; d_vgpr = knl_vgpr_per_wf;
    d_sgpr = knl_sgpr_per_wf; d_lds = knl_lds_size;
    check("knl_ready_before", knl_ready, 1'b1);
    knl_valid = 1'b1;
    @(negedge clk);
    knl_valid = 1'b0;
    rand_desc($urandom_range(50));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_v = last_hs ? 1'b0 : last_v ? 1'b1 : (cyc > 0 && prev_iss < n && prev_out < MAXI);
      check("req_valid", req_valid, exp_v);
      check("busy", busy, 1'b1);
      if (req_valid) begin
        e_pds = d_base + MA'(issued) * d_stride;
        check("wg_id", req_wg_id, WG'(issued));
        check("pds", req_pds, e_pds);
        check("totals", {req_vgpr_total, req_sgpr_total},
              {(VG+1)'((int'(d_num_wf) * int'(d_vgpr)) % (1 << (VG+1))),
               (SG+1)'((int'(d_num_wf) * int'(d_sgpr)) % (1 << (SG+1)))});
        check("pass_a", {req_num_wf, req_wf_size, req_lds_total, req_vgpr_per_wf, req_sgpr_per_wf},
              {d_num_wf, d_wf_size, d_lds, d_vgpr, d_sgpr});
        check("pass_b", {req_start_pc, req_csr}, {d_pc, d_csr});
        check("zero_fields", {req_ksize, req_gds_size, req_gds_base}, 64'd0);
      end
      if (kernel_done) begin
        check("done_after_all_rsp", responded, n);
        check("done_issued", issued, n);
        seen_done = 1'b1;
        break;
      end
      prev_iss = issued;
      prev_out = issued - responded;
      rdy = ($urandom_range(99) < rdy_pct);
      req_ready = rdy;
      last_hs = req_valid && rdy;
      last_v  = req_valid;
      if (last_hs) begin
        ids.push_back(issued);
        due.push_back(cyc + $urandom_range(lat_max, lat_min));
        issued++;
      end
      if (issued - responded > max_out) max_out = issued - responded;
      rsp_valid = 1'b0;
      if (bogus && cyc == 0) begin
        rsp_valid = 1'b1;
        rsp_wg_id = WG'($urandom);
      end else begin
        j = -1;
        foreach (due[k]) if (j < 0 && due[k] <= cyc) j = k;
        if (j >= 0) begin
          check("rsp_ready", rsp_ready, 1'b1);
          rsp_valid = 1'b1;
          rsp_wg_id = WG'(ids[j]);
          ids.delete(j);
          due.delete(j);
          responded++;
        end
      end
      if (abort_at > 0 && issued == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort_reset");
        check("abort_payload", {req_wg_id, req_pds}, 64'd0);
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end else begin
      check("done_seen", seen_done, 1'b1);
      @(negedge clk);
      check_idle_outputs("after_done");
    end
  endtask

  int mo;

  initial begin
    rst_n = 1'b0; knl_valid = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_wg_id = '0;
    rand_desc(0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_payload", {req_wg_id, req_pds}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    rand_desc(4);
    knl_num_wf = 4'd2; knl_vgpr_per_wf = 11'd8; knl_sgpr_per_wf = 11'd4;
    knl_pds_base = 32'h1000; knl_pds_stride = 32'h100;
    run_kernel(4, 100, 10, 10, 1'b0, 0, mo);

    rand_desc(12);
    run_kernel(12, 100, 200, 220, 1'b0, 0, mo);
    check("max_inflight", mo, MAXI);

    rand_desc(6);
    run_kernel(6, 30, 1, 15, 1'b0, 0, mo);

    rand_desc(5);
    run_kernel(5, 100, 3, 6, 1'b1, 0, mo);

    rand_desc(0);
    run_kernel(0, 100, 1, 1, 1'b0, 0, mo);

    rand_desc(10);
    run_kernel(10, 100, 500, 500, 1'b0, 2, mo);
    rand_desc(3);
    run_kernel(3, 100, 2, 8, 1'b0, 0, mo);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = $urandom_range(20, 1);
      rand_desc(n);
      run_kernel(n, $urandom_range(100, 20), 1, $urandom_range(30, 1), 1'b0, 0, mo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
